led_pwm_drv: RTL and testbench

LED_PWM_DRV -- requirements
Module: led_pwm_drv

---
 rtl/led_pwm_drv_pkg.sv | 14 +
 rtl/pwm_tick_gen.sv | 36 +++
 rtl/led_pwm_drv.sv | 138 +++++++++++++
 tb/tb_led_pwm_drv.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_drv_pkg.sv
// Shared types and constants for the 8-channel staggered LED PWM driver.
package led_pwm_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int PH_W   = 8;
  localparam int CH_OFS = 32;
  localparam int N_CH   = 8;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: one tick every PRESCALE clk cycles while running.
module pwm_tick_gen #(
  parameter int PRESCALE = 195
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = run && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pwm_drv.sv
// 8-channel LED PWM driver with staggered channel phases,
// period-aligned duty updates and a graceful drain-to-idle stop.
module led_pwm_drv
  import led_pwm_drv_pkg::*;
#(
  parameter int PRESCALE   = 195,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [PH_W-1:0] duty_in,
  output logic [N_CH-1:0] pwm_out,
  output logic            period_done,
  output logic            busy
);

  localparam logic [N_CH-1:0] OFF =
    ACTIVE_LOW ? {N_CH{1'b1}} : {N_CH{1'b0}};

  state_e          state_q;
  logic [PH_W-1:0] duty_s1_q;
  logic [PH_W-1:0] duty_s2_q;
  logic [PH_W-1:0] shadow_q;
  logic [PH_W-1:0] ph_q;
  logic [N_CH-1:0] pwm_q;
  logic            pd_q;
  logic            busy_q;

  logic            tick;
  logic            idle;
  logic            boundary;
  logic            go;
  logic            stop;
  logic [N_CH-1:0] on_d;
  logic [PH_W-1:0] rel;

  assign idle     = (state_q == IDLE);
  assign boundary = tick && (ph_q == {PH_W{1'b1}});
  assign go       = idle && en;
  assign stop     = (state_q == DRAIN) && !en && boundary;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(idle),
    .run  (!idle),
    .tick (tick)
  );

  // Channel i is shifted back by i*CH_OFS steps on the shared phase.
  always_comb begin
    on_d = '0;
    rel  = '0;
    for (int i = 0; i < N_CH; i++) begin
      rel     = ph_q - PH_W'(i * CH_OFS);
      on_d[i] = (rel < shadow_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_s1_q <= '0;
      duty_s2_q <= '0;
    end else begin
      duty_s1_q <= duty_in;
      duty_s2_q <= duty_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q     <= '0;
      shadow_q <= '0;
    end else begin
      if (idle) begin
        ph_q <= '0;
      end else if (tick) begin
        ph_q <= ph_q + 1'b1;
      end
      if (go || boundary) begin
        shadow_q <= duty_s2_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pwm_q   <= OFF;
      pd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pd_q <= boundary;
      unique case (state_q)
        IDLE: begin
          pwm_q <= OFF;
          if (en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          pwm_q  <= on_d ^ OFF;
          busy_q <= 1'b1;
          if (!en) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (stop) begin
            state_q <= IDLE;
            pwm_q   <= OFF;
            busy_q  <= 1'b0;
          end else begin
            pwm_q  <= on_d ^ OFF;
            busy_q <= 1'b1;
            if (en) begin
              state_q <= RUN;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pwm_q   <= OFF;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = pd_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_led_pwm_drv.sv
// Directed bench for led_pwm_drv: phase/duty vector table
// plus hand-built start, drain, reset and active-low sequences.
module tb_led_pwm_drv;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] duty, pwm;
  logic       pd, busy;
  logic       rst2, en2;
  logic [7:0] duty2, pwm2;
  logic       pd2, busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pwm_drv #(
    .PRESCALE(1),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .duty_in(duty),
    .pwm_out(pwm),
    .period_done(pd),
    .busy(busy)
  );

  led_pwm_drv #(
    .PRESCALE(1),
    .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk),
    .rst(rst2),
    .en(en2),
    .duty_in(duty2),
    .pwm_out(pwm2),
    .period_done(pd2),
    .busy(busy2)
  );

  typedef struct {
    logic [7:0] duty;
    int         ph;
    logic [7:0] exp_pwm;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en = 1'b0;
    duty = 8'd0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Leaves the bench just after the IDLE->RUN edge (ph=0).
  task automatic start(input logic [7:0] d);
    duty = d;
    step();
    step();
    step();
    en = 1'b1;
    step();
  endtask

  initial begin
    int b0, b1, pdc, pdat, pdat2, nz;
    int r0, r1, f0;
    logic [7:0] prev;

    vt[0] = '{8'd0,   5,   8'h00};
    vt[1] = '{8'd128, 0,   8'hE1};
    vt[2] = '{8'd128, 40,  8'hC3};
    vt[3] = '{8'd255, 255, 8'hFE};
    vt[4] = '{8'd255, 31,  8'hFD};
    vt[5] = '{8'd1,   64,  8'h04};
    vt[6] = '{8'd64,  100, 8'h0C};
    vt[7] = '{8'd200, 10,  8'hF9};

    rst = 1'b1; en = 1'b0; duty = 8'd0;
    rst2 = 1'b1; en2 = 1'b0; duty2 = 8'd0;
    #1;
    chk("rst_pwm", pwm, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_pd", pd, 0);
    chk("rst_pwm_al", pwm2, 8'hFF);
    step();
    rst = 1'b0;
    step();
    step();
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      start(vt[v].duty);
      b0 = 0; pdc = 0; pdat = -1;
      for (int c = 1; c <= 256; c++) begin
        step();
        if (c == vt[v].ph + 1)
          chk($sformatf("vec%0d_pwm", v), pwm, vt[v].exp_pwm);
        b0 += int'(pwm[0]);
        if (pd) begin
          pdc++;
          pdat = c;
        end
      end
      chk($sformatf("vec%0d_b0cnt", v), b0, vt[v].duty);
      chk($sformatf("vec%0d_pdcnt", v), pdc, 1);
      chk($sformatf("vec%0d_pdat", v), pdat, 256);
    end

    // Zero duty over two periods
    do_reset();
    start(8'd0);
    nz = 0; pdc = 0; pdat = -1; pdat2 = -1;
    for (int c = 1; c <= 512; c++) begin
      step();
      if (pwm != 8'h00) nz++;
      if (pd) begin
        pdc++;
        if (pdat < 0) pdat = c;
        else pdat2 = c;
      end
    end
    chk("zero_nz", nz, 0);
    chk("zero_pdcnt", pdc, 2);
    chk("zero_gap", pdat2 - pdat, 256);

    // Half duty: run length and channel stagger
    do_reset();
    start(8'd128);
    r0 = -1; r1 = -1; f0 = -1;
    prev = pwm;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (c > 200) begin
        if (pwm[0] && !prev[0] && r0 < 0) r0 = c;
        if (pwm[1] && !prev[1] && r1 < 0) r1 = c;
        if (!pwm[0] && prev[0] && r0 > 0 && f0 < 0)
          f0 = c;
      end
      prev = pwm;
    end
    chk("half_rise0", r0, 257);
    chk("half_stagger", r1 - r0, 32);
    chk("half_runlen", f0 - r0, 128);

    // Duty change mid-period takes effect next period
    do_reset();
    start(8'd64);
    b0 = 0; b1 = 0;
    for (int c = 1; c <= 512; c++) begin
      step();
      if (c == 100) duty = 8'd192;
      if (c <= 256) b0 += int'(pwm[0]);
      else b1 += int'(pwm[0]);
    end
    chk("chg_cur", b0, 64);
    chk("chg_next", b1, 192);

    // Graceful drain to idle
    do_reset();
    start(8'd128);
    for (int c = 1; c <= 260; c++) begin
      step();
      if (c == 255) chk("drain_busy255", busy, 1);
      if (c == 256) begin
        chk("drain_pd", pd, 1);
        chk("drain_busy", busy, 0);
        chk("drain_pwm", pwm, 8'h00);
      end
      if (c == 258) chk("drain_stay", busy, 0);
      if (c == 10) en = 1'b0;
    end

    // Re-enable during drain cancels the stop
    do_reset();
    start(8'd128);
    for (int c = 1; c <= 300; c++) begin
      step();
      if (c == 256) begin
        chk("redo_pd", pd, 1);
        chk("redo_busy256", busy, 1);
      end
      if (c == 300) chk("redo_busy300", busy, 1);
      if (c == 10) en = 1'b0;
      if (c == 50) en = 1'b1;
    end

    // en drop on the boundary cycle: one full extra period
    do_reset();
    start(8'd128);
    for (int c = 1; c <= 520; c++) begin
      step();
      if (c == 256) begin
        chk("late_pd1", pd, 1);
        chk("late_busy1", busy, 1);
      end
      if (c == 511) chk("late_busy511", busy, 1);
      if (c == 512) begin
        chk("late_pd2", pd, 1);
        chk("late_busy2", busy, 0);
      end
      if (c == 255) en = 1'b0;
    end

    // Asynchronous reset mid-period
    do_reset();
    start(8'd100);
    for (int c = 1; c <= 77; c++) step();
    chk("arst_pre_b0", pwm[0], 1);
    rst = 1'b1;
    #1;
    chk("arst_pwm", pwm, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_pd", pd, 0);
    chk("arst_ph", dut.ph_q, 0);
    en = 1'b0;
    step();
    step();
    rst = 1'b0;
    nz = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (busy || pd) nz++;
    end
    chk("arst_idle", nz, 0);
    chk("arst_ph_after", dut.ph_q, 0);

    // Active-low output at full duty
    duty2 = 8'd255;
    step();
    rst2 = 1'b0;
    step();
    step();
    step();
    en2 = 1'b1;
    step();
    b0 = 0; b1 = 0;
    for (int c = 1; c <= 256; c++) begin
      step();
      if (pwm2[0]) b1++;
      else b0++;
      if (c == 256) chk("al_ph255", pwm2[0], 1);
    end
    chk("al_low", b0, 255);
    chk("al_high", b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
